// File: rtl/mac_pkg.sv
// Shared types for the MAC operand feeder: FSM states and the buffered operand pair.
package mac_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    CLEAR
  } feeder_state_t;

  typedef struct packed {
    logic signed [DEFAULT_DATA_W-1:0] a;
    logic signed [DEFAULT_DATA_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous FIFO of operand pairs; pointers wrap modulo DEPTH (power of 2).
module mac_operand_fifo
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  operand_pair_t                wr_data,
  output operand_pair_t                rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  operand_pair_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs and streams VEC_LEN-pair dot products into the MAC, then
// drains and clears it. Define MAC_FEEDER_STATS_EN to add vec_count/bubble_count.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            in_a,
  input  logic [DATA_W-1:0]            in_b,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            mac_a,
  output logic [DATA_W-1:0]            mac_b,
  output logic                         mac_valid_in,
  output logic                         mac_clr,
  output logic                         vec_done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef MAC_FEEDER_STATS_EN
  ,
  output logic [15:0]                  vec_count,
  output logic [15:0]                  bubble_count
`endif
);

  localparam int unsigned ELEM_W  = $clog2(VEC_LEN + 1);
  localparam int unsigned DRAIN_W = $clog2(MAC_LAT + 1);

  feeder_state_t      state;
  feeder_state_t      state_next;
  logic [ELEM_W-1:0]  elem_cnt;
  logic [ELEM_W-1:0]  elem_next;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_next;
  logic               pop;
  logic               push;
  logic               full;
  logic               empty;
  operand_pair_t      wr_pair;
  operand_pair_t      rd_pair;

  // in_ready is held low during reset so nothing is accepted until release.
  assign in_ready = reset_n && !full;
  assign push     = in_valid && in_ready;
  assign wr_pair  = '{a: in_a, b: in_b};
  assign mac_clr  = (state == CLEAR);
  assign vec_done = (state == CLEAR);

  mac_operand_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_pair),
    .rd_data (rd_pair),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      elem_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      elem_cnt  <= elem_next;
      drain_cnt <= drain_next;
    end
  end

  always_comb begin
    state_next = state;
    elem_next  = elem_cnt;
    drain_next = drain_cnt;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (VEC_LEN == 1) begin
            state_next = DRAIN;
            elem_next  = '0;
          end else begin
            state_next = STREAM;
            elem_next  = ELEM_W'(1);
          end
        end
      end
      STREAM: begin
        if (!empty) begin
          pop = 1'b1;
          if (elem_cnt == ELEM_W'(VEC_LEN - 1)) begin
            state_next = DRAIN;
            elem_next  = '0;
          end else begin
            elem_next = elem_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Last pop was the edge entering DRAIN; MAC_LAT cycles later the clear starts.
        if (drain_cnt == DRAIN_W'(MAC_LAT - 1)) begin
          state_next = CLEAR;
          drain_next = '0;
        end else begin
          drain_next = drain_cnt + 1'b1;
        end
      end
      CLEAR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_a        <= '0;
      mac_b        <= '0;
      mac_valid_in <= 1'b0;
    end else begin
      mac_valid_in <= pop;
      if (pop) begin
        mac_a <= rd_pair.a;
        mac_b <= rd_pair.b;
      end else begin
        mac_a <= '0;
        mac_b <= '0;
      end
    end
  end

`ifdef MAC_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_count    <= '0;
      bubble_count <= '0;
    end else begin
      if (state == CLEAR) vec_count <= vec_count + 1'b1;
      if (state == STREAM && empty && bubble_count != '1)
        bubble_count <= bubble_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a behavioural accumulator standing in for the MAC.
module tb_mac_operand_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mac_a;
  logic [7:0]  mac_b;
  logic        mac_valid_in;
  logic        mac_clr;
  logic        vec_done;
  logic [3:0]  fifo_count;
`ifdef MAC_FEEDER_STATS_EN
  logic [15:0] vec_count;
  logic [15:0] bubble_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mac_operand_feeder #(
    .DATA_W  (8),
    .DEPTH   (8),
    .VEC_LEN (4),
    .MAC_LAT (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mac_a        (mac_a),
    .mac_b        (mac_b),
    .mac_valid_in (mac_valid_in),
    .mac_clr      (mac_clr),
    .vec_done     (vec_done),
    .fifo_count   (fifo_count)
`ifdef MAC_FEEDER_STATS_EN
    ,
    .vec_count    (vec_count),
    .bubble_count (bubble_count)
`endif
  );

  always #5 clk = ~clk;

  // Downstream MAC: 16-bit signed accumulator with sticky overflow flag.
  int   f;
  logic ovf;
  int   prod;
  assign prod = $signed(mac_a) * $signed(mac_b);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f   <= 0;
      ovf <= 1'b0;
    end else if (mac_clr) begin
      f   <= 0;
      ovf <= 1'b0;
    end else if (mac_valid_in) begin
      f   <= f + prod;
      ovf <= ovf || (f + prod > 32767) || (f + prod < -32768);
    end
  end

  int          clr_count   = 0;
  int          overlap_err = 0;
  logic        prev_clr    = 1'b0;
  logic [15:0] issued [$];

  always @(posedge clk) begin
    if (mac_clr) clr_count++;
    if (mac_valid_in) issued.push_back({mac_a, mac_b});
    if (prev_clr && mac_valid_in) overlap_err++;
    prev_clr = mac_clr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    tick();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] pa(input int k);
    return 8'(k * 7 + 1);
  endfunction

  function automatic logic [7:0] pb(input int k);
    return 8'(200 - k);
  endfunction

  int   base_clr;
  int   base_iss;
  int   idx;
  int   peak;
  logic acc;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", mac_valid_in, 0);
    check("rst_clr", mac_clr, 0);
    check("rst_count", fifo_count, 0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // 1: back-to-back vector, f=770 held until the clear
    in_valid = 1; in_a = 2; in_b = 2; tick();
    check("t1_count", fifo_count, 1);
    in_a = 3; in_b = 8'hFD; tick();
    check("t1_v1", mac_valid_in, 1);
    check("t1_a1", mac_a, 2);
    in_a = 5; in_b = 5; tick();
    check("t1_b2", mac_b, 8'hFD);
    in_a = 50; in_b = 15; tick();
    check("t1_a3", mac_a, 5);
    in_valid = 0; tick();
    check("t1_v4", mac_valid_in, 1);
    check("t1_ab4", {mac_a, mac_b}, {8'd50, 8'd15});
    tick();
    check("t1_v5", mac_valid_in, 0);
    check("t1_noclr1", mac_clr, 0);
    tick();
    check("t1_noclr2", mac_clr, 0);
    tick();
    check("t1_clr", mac_clr, 1);
    check("t1_done", vec_done, 1);
    check("t1_f", f, 770);
    tick();
    check("t1_clr_off", mac_clr, 0);
    check("t1_f0", f, 0);

    // 2: bubbles in STREAM
    do_reset();
    base_clr = clr_count;
    in_valid = 1; in_a = 1; in_b = 1; tick();
    in_a = 2; in_b = 2; tick();
    check("t2_a1", mac_a, 1);
    in_valid = 0; tick();
    check("t2_a2", mac_a, 2);
    tick();
    check("t2_bub1", mac_valid_in, 0);
    tick();
    check("t2_bub2", mac_valid_in, 0);
    in_valid = 1; in_a = 3; in_b = 3; tick();
    check("t2_bub3", mac_valid_in, 0);
    in_a = 4; in_b = 4; tick();
    check("t2_a3", mac_a, 3);
    in_valid = 0; tick();
    check("t2_a4", mac_a, 4);
    tick(); tick();
    check("t2_noclr", mac_clr, 0);
    tick();
    check("t2_clr", mac_clr, 1);
    check("t2_f", f, 30);
    tick();
    check("t2_one_clr", clr_count - base_clr, 1);
`ifdef MAC_FEEDER_STATS_EN
    check("t2_bubble_count", bubble_count, 3);
    check("t2_vec_count", vec_count, 1);
`endif

    // 3: warm-up vector, then 12 pairs held valid; FIFO fills during drain
    do_reset();
    base_clr = clr_count;
    base_iss = issued.size();
    peak = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_a = pa(k); in_b = pb(k); tick();
    end
    in_valid = 0; tick();
    idx = 4;
    in_valid = 1; in_a = pa(4); in_b = pb(4);
    for (int c = 0; c < 100 && idx < 16; c++) begin
      acc = in_ready;
      tick();
      if (acc) idx++;
      if (idx < 16) begin
        in_a = pa(idx); in_b = pb(idx);
      end else begin
        in_valid = 0;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (fifo_count == 4'd8) check("t3_ready_low_full", in_ready, 0);
    end
    in_valid = 0;
    check("t3_all_accepted", idx, 16);
    check("t3_peak", peak, 8);
    for (int c = 0; c < 100 && (clr_count - base_clr) != 4; c++) tick();
    check("t3_vec_done_pulses", clr_count - base_clr, 4);
    check("t3_issued_n", issued.size() - base_iss, 16);
    for (int k = 0; k < 16; k++) begin
      if (base_iss + k < issued.size())
        check($sformatf("t3_pair%0d", k), issued[base_iss + k], {pa(k), pb(k)});
    end

    // 4: values that overflow the MAC pass through unchanged
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_a = 125; in_b = 100; tick();
      if (k >= 1) check($sformatf("t4_ab%0d", k), {mac_a, mac_b}, {8'h7D, 8'h64});
    end
    in_valid = 0; tick();
    check("t4_ab4", {mac_valid_in, mac_a, mac_b}, {1'b1, 8'h7D, 8'h64});
    tick(); tick(); tick();
    check("t4_clr", mac_clr, 1);
    check("t4_ovf", ovf, 1);

    // 5: reset mid-vector, then a fresh vector
    do_reset();
    base_clr = clr_count;
    in_valid = 1; in_a = 20; in_b = 20; tick(); tick(); tick();
    check("t5_issue2", mac_valid_in, 1);
    reset_n = 0; in_valid = 0;
    #1;
    check("t5_rst_outs", {mac_valid_in, mac_clr, vec_done, in_ready, mac_a, mac_b}, '0);
    check("t5_rst_count", fifo_count, 0);
    tick(); tick();
    reset_n = 1;
    for (int c = 0; c < 6; c++) tick();
    check("t5_no_clr", clr_count - base_clr, 0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_a = 8'(2 * k + 1); in_b = 8'(2 * k + 2); tick();
      if (k == 1) check("t5_first", {mac_valid_in, mac_a, mac_b}, {1'b1, 8'd1, 8'd2});
    end
    in_valid = 0; tick();
    tick(); tick(); tick();
    check("t5_clr", mac_clr, 1);
    check("t5_f", f, 100);

    // 6: pushes during DRAIN and CLEAR wait for IDLE
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_a = 8'(k + 1); in_b = 1; tick();
    end
    in_valid = 0; tick();
    in_valid = 1; in_a = 9; in_b = 9;
    check("t6_ready_drain", in_ready, 1);
    tick();
    in_valid = 0;
    check("t6_count_drain", fifo_count, 1);
    check("t6_no_issue_drain", mac_valid_in, 0);
    tick(); tick();
    check("t6_clr", mac_clr, 1);
    check("t6_ready_clear", in_ready, 1);
    in_valid = 1; in_a = 10; in_b = 10; tick();
    in_valid = 0;
    check("t6_no_issue_clear", mac_valid_in, 0);
    check("t6_count_clear", fifo_count, 2);
    tick();
    check("t6_issue_idle", {mac_valid_in, mac_a}, {1'b1, 8'd9});
    check("t6_count_after", fifo_count, 1);
    tick();
    check("t6_issue_next", mac_a, 10);
    check("t6_no_pop_on_clr", overlap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
